demux_16_stream: RTL and testbench
==================================

// Module: demux_16_stream
// PURPOSE
//  1-to-16 scatter unit: routes one WIDTH-bit input word to one of 16 output channels chosen by a 4-bit select.
//  Each channel has a one-entry holding register with its own valid/ready handshake.
//  Sits on the writeback/distribution side of the datapath, opposite the 16:1 read-select tree.
//  Registered path: a word accepted in cycle N is presented on its channel in cycle N+1.
// PARAMETERS
//  WIDTH    32   data word width in bits
//  NCH      16   channel count; fixed at 16 (select is 4 bits)
// PORTS
//  clock      in   1            single clock, rising edge
//  reset_n    in   1            asynchronous, active-low reset
//  in_valid   in   1            input word present
//  in_ready   out  1            input word accepted this cycle when in_valid & in_ready
//  select     in   4            target channel index, sampled with in_data
//  in_data    in   WIDTH        input word
//  out_valid  out  16           bit i: channel i holding register full
//  out_ready  in   16           bit i: channel i consumer takes word this cycle
//  out_data   out  16*WIDTH     channel i data at [i*WIDTH +: WIDTH]
//  occupancy  out  5            number of full channel registers, 0..16
// BEHAVIOUR
//  - Reset (reset_n low, async): all out_valid=0, out_data=0, occupancy=0; reset mid-transfer discards held words.
//  - Decode: one-hot wr_en[i] = in_valid & in_ready & (select==i); at most one slot written per cycle.
//  - in_ready = ~out_valid[select] | out_ready[select] (combinational; depends only on the addressed slot).
//  - Slot i, per clock: drain = out_valid[i] & out_ready[i]; fill = wr_en[i].
//    fill -> out_valid[i]<=1, out_data[i]<=in_data (overrides drain; full-throughput same-slot refill);
//    drain & ~fill -> out_valid[i]<=0, data held (don't-care); neither -> hold.
//  - out_ready[i] while out_valid[i]=0 is ignored; out_data stable while out_valid & ~out_ready.
//  - Latency: 1 cycle accept-to-present; 1 word/cycle sustained to any single channel or across channels.
//  - occupancy <= occupancy + fills - drains (fills 0/1, drains 0..16); saturating never required, range 0..16 by construction.
//  - Blocked input: if the addressed slot is full and not draining, in_ready=0; in_valid/select/in_data held by the producer.
//  - Select change while stalled is legal; in_ready re-evaluates for the new target.
// CONFIGURATION
//  DEMUX16_BCAST_EN defined: extra input in_bcast (1); when in_valid & in_bcast, select is ignored,
//    in_ready = &(~out_valid | out_ready), and on accept all 16 slots load in_data; occupancy <= 16.
//  Not defined: no in_bcast port; unicast only, behaviour exactly as above.
// STRUCTURE
//  - Shared package demux16_pkg: NCH=16, SEL_W=4, OCC_W=5 constants, default WIDTH.
//  - Sub-module demux16_slot: one-entry holding register (fill/drain/valid/data), instantiated 16x via generate.
//  - Top: 4-to-16 write decoder, in_ready mux over slot state, occupancy counter (popcount-free: +fill -drain count).
// TESTING
//  1. Reset: hold reset_n=0 with in_valid=1 -> out_valid=16'h0000, occupancy=0, out_data=0; release, no spurious writes.
//  2. Unicast: select=4'd5, in_data=32'hDEADBEEF, out_ready=0 -> next cycle out_valid=16'h0020, ch5 data DEADBEEF, occupancy=1.
//  3. Backpressure: ch5 full, out_ready[5]=0, send select=5 -> in_ready=0, ch5 data unchanged; assert out_ready[5] -> in_ready=1, ch5 reloads new word next cycle, occupancy stays 1.
//  4. Streaming all channels: select 0..15 on consecutive cycles, out_ready=0 -> out_valid=16'hFFFF after 16 cycles, occupancy=16; drain all at once -> occupancy=0 next cycle.
//  5. Simultaneous fill ch3 / drain ch9 -> occupancy unchanged, out_valid[3]=1, out_valid[9]=0.
//  6. DEMUX16_BCAST_EN: in_bcast=1, data 32'h00000001, all slots empty -> out_valid=16'hFFFF, all channels 1, occupancy=16; with any slot stalled -> in_ready=0.

Source files
------------

// File: rtl/demux16_pkg.sv
// Shared constants for the 1-to-16 stream demux.
package demux16_pkg;
  localparam int NCH       = 16;
  localparam int SEL_W     = 4;
  localparam int OCC_W     = 5;
  localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/demux16_slot.sv
// One-entry channel holding register; a fill wins over a same-cycle drain.
module demux16_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             fill,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic             vld,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (fill) begin
      vld  <= 1'b1;
      dout <= din;
    end else if (vld && take) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_16_stream.sv
// 1-to-16 registered scatter unit with per-channel valid/ready.
// Optional broadcast load of all channels under DEMUX16_BCAST_EN.
import demux16_pkg::*;

module demux_16_stream #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     select,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
`ifdef DEMUX16_BCAST_EN
  input  logic                 in_bcast,
`endif
  output logic [OCC_W-1:0]     occupancy
);

  logic [NCH-1:0]   slot_free;
  logic [NCH-1:0]   wr_en;
  logic             accept;
  logic             bcast;
  logic [OCC_W-1:0] drain_cnt;
  logic [OCC_W-1:0] occ_nxt;

`ifdef DEMUX16_BCAST_EN
  assign bcast = in_valid & in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A slot can take a word if empty or being emptied this same cycle.
  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = bcast ? (&slot_free) : slot_free[select];
  assign accept    = in_valid & in_ready;

  always_comb begin
    wr_en = '0;
    if (accept) wr_en = bcast ? '1 : (NCH'(1) << select);
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_slot
      demux16_slot #(.WIDTH(WIDTH)) u_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .fill    (wr_en[i]),
        .take    (out_ready[i]),
        .din     (in_data),
        .vld     (out_valid[i]),
        .dout    (out_data[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Refill of a draining slot nets to zero: +1 fill, -1 drain.
  always_comb begin
    drain_cnt = '0;
    for (int i = 0; i < NCH; i++)
      drain_cnt = drain_cnt + OCC_W'(out_valid[i] & out_ready[i]);
    occ_nxt = occupancy + OCC_W'(accept) - drain_cnt;
    if (accept && bcast) occ_nxt = OCC_W'(NCH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) occupancy <= '0;
    else          occupancy <= occ_nxt;
  end

endmodule

// File: tb/tb_demux_16_stream.sv
// Self-checking bench for demux_16_stream against a per-channel array model.
module tb_demux_16_stream;
  localparam int W = 32;
  localparam int N = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      select;
  logic [W-1:0]    in_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*W-1:0]  out_data;
  logic [4:0]      occupancy;
`ifdef DEMUX16_BCAST_EN
  logic            in_bcast = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: which channels hold a word, and what word.
  bit          mv [N];
  logic [W-1:0] md [N];

  demux_16_stream #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef DEMUX16_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  function automatic bit is_bcast();
`ifdef DEMUX16_BCAST_EN
    return in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_ready();
    bit r;
    if (in_valid && is_bcast()) begin
      r = 1'b1;
      for (int i = 0; i < N; i++) if (mv[i] && !out_ready[i]) r = 1'b0;
    end else begin
      r = !mv[select] || out_ready[select];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] model_vld();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mv[i];
    return v;
  endfunction

  function automatic logic [4:0] model_occ();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mv[i]);
    return 5'(c);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
  endfunction

  // Advance one clock, applying the channel rules to the model.
  task automatic tick();
    bit nv [N];
    logic [W-1:0] nd [N];
    bit acc;
    acc = in_valid && model_ready();
    for (int i = 0; i < N; i++) begin
      nv[i] = mv[i];
      nd[i] = md[i];
      if (acc && (is_bcast() || select == 4'(i))) begin
        nv[i] = 1'b1;
        nd[i] = in_data;
      end else if (mv[i] && out_ready[i]) begin
        nv[i] = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      mv[i] = nv[i];
      md[i] = nd[i];
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; select = 4'd2; in_data = 32'h12345678;
    out_ready = '0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 16'h0000) begin
      failures++; $display("FAIL reset_valid got=%h exp=%h", out_valid, 16'h0000);
    end
    checks++;
    if (occupancy !== 5'd0) begin
      failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy);
    end
    checks++;
    if (out_data !== '0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", out_data);
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    checks++;
    if (out_valid !== 16'h0000 || occupancy !== 5'd0) begin
      failures++;
      $display("FAIL reset_release got vld=%h occ=%0d exp vld=0000 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_unicast();
    select = 4'd5; in_data = 32'hDEADBEEF; out_ready = '0; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL uni_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 16'h0020) begin
      failures++; $display("FAIL uni_valid got=%h exp=0020", out_valid);
    end
    checks++;
    if (out_data[5*W +: W] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL uni_data got=%h exp=deadbeef", out_data[5*W +: W]);
    end
    checks++;
    if (occupancy !== 5'd1) begin
      failures++; $display("FAIL uni_occ got=%0d exp=1", occupancy);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; select = 4'd5; in_data = 32'hCAFEF00D; out_ready = '0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_stall_ready got=%b exp=0", in_ready);
    end
    // Retarget while stalled: an empty channel should be accepted.
    select = 4'd6;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_retarget_ready got=%b exp=1", in_ready);
    end
    select = 4'd5;
    tick();
    checks++;
    if (out_data[5*W +: W] !== 32'hDEADBEEF || occupancy !== 5'd1) begin
      failures++;
      $display("FAIL bp_hold got data=%h occ=%0d exp data=deadbeef occ=1", out_data[5*W +: W], occupancy);
    end
    out_ready[5] = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0; out_ready = '0;
    checks++;
    if (out_data[5*W +: W] !== 32'hCAFEF00D || out_valid !== 16'h0020 || occupancy !== 5'd1) begin
      failures++;
      $display("FAIL bp_reload got data=%h vld=%h occ=%0d exp data=cafef00d vld=0020 occ=1",
               out_data[5*W +: W], out_valid, occupancy);
    end
  endtask

  task automatic test_stream_all();
    in_valid = 1'b0; out_ready = '1;
    tick();
    out_ready = '0;
    for (int s = 0; s < N; s++) begin
      in_valid = 1'b1; select = 4'(s); in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 16'hFFFF || occupancy !== 5'd16) begin
      failures++; $display("FAIL stream_full got vld=%h occ=%0d exp vld=ffff occ=16", out_valid, occupancy);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_data[i*W +: W] !== md[i]) begin
        failures++; $display("FAIL stream_data ch=%0d got=%h exp=%h", i, out_data[i*W +: W], md[i]);
      end
    end
    out_ready = '1;
    tick();
    out_ready = '0;
    checks++;
    if (out_valid !== 16'h0000 || occupancy !== 5'd0) begin
      failures++; $display("FAIL stream_drain got vld=%h occ=%0d exp vld=0000 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_fill_drain();
    in_valid = 1'b1; select = 4'd9; in_data = 32'h99999999;
    tick();
    select = 4'd3; in_data = 32'h33333333; out_ready = 16'h0200;
    tick();
    in_valid = 1'b0; out_ready = '0;
    checks++;
    if (occupancy !== 5'd1 || out_valid[3] !== 1'b1 || out_valid[9] !== 1'b0) begin
      failures++;
      $display("FAIL fill_drain got occ=%0d v3=%b v9=%b exp occ=1 v3=1 v9=0", occupancy, out_valid[3], out_valid[9]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      select    = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = 16'($urandom) & 16'($urandom);
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== model_vld() || occupancy !== model_occ()) begin
        failures++;
        $display("FAIL rnd_state cyc=%0d got vld=%h occ=%0d exp vld=%h occ=%0d",
                 c, out_valid, occupancy, model_vld(), model_occ());
      end
      for (int i = 0; i < N; i++) begin
        if (mv[i]) begin
          checks++;
          if (out_data[i*W +: W] !== md[i]) begin
            failures++; $display("FAIL rnd_data cyc=%0d ch=%0d got=%h exp=%h", c, i, out_data[i*W +: W], md[i]);
          end
        end
      end
    end
    in_valid = 1'b0; out_ready = '0;
  endtask

  task automatic test_async_reset();
    // Fill a few channels, then drop reset between clock edges.
    for (int s = 0; s < 4; s++) begin
      in_valid = 1'b1; select = 4'(s * 3); in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (out_valid !== 16'h0000 || occupancy !== 5'd0 || out_data !== '0) begin
      failures++; $display("FAIL async_reset got vld=%h occ=%0d exp vld=0000 occ=0", out_valid, occupancy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

`ifdef DEMUX16_BCAST_EN
  task automatic test_bcast();
    out_ready = '1; in_valid = 1'b0;
    tick();
    out_ready = '0;
    in_valid = 1'b1; in_bcast = 1'b1; select = 4'd7; in_data = 32'h00000001;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bcast_ready_empty got=%b exp=1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 16'hFFFF || occupancy !== 5'd16) begin
      failures++; $display("FAIL bcast_fill got vld=%h occ=%0d exp vld=ffff occ=16", out_valid, occupancy);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_data[i*W +: W] !== 32'h00000001) begin
        failures++; $display("FAIL bcast_data ch=%0d got=%h exp=00000001", i, out_data[i*W +: W]);
      end
    end
    out_ready = 16'hFFFF & ~16'h0100;
    in_data = 32'h2;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bcast_stall_ready got=%b exp=0", in_ready);
    end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = '1;
    tick();
    out_ready = '0;
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_unicast();
    test_backpressure();
    test_stream_all();
    test_fill_drain();
    test_random();
    test_async_reset();
`ifdef DEMUX16_BCAST_EN
    test_bcast();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
